// File: rtl/mips_pkg.sv
// Shared codes and defaults for the MIPS pipeline writeback path.
package mips_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int CNT_W_DEF   = 32;
  localparam int LINK_OFFSET = 8;

  typedef enum logic [1:0] {
    WBSEL_ALU  = 2'b00,
    WBSEL_LOAD = 2'b01,
    WBSEL_LINK = 2'b10,
    WBSEL_RSVD = 2'b11
  } wbsel_e;

  typedef enum logic [1:0] {
    LDSIZE_WORD = 2'b00,
    LDSIZE_HALF = 2'b01,
    LDSIZE_BYTE = 2'b10,
    LDSIZE_RSVD = 2'b11
  } ldsize_e;

endpackage

// File: rtl/load_extract.sv
// Big-endian sub-word load extraction with sign/zero extension and alignment check.
module load_extract
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] load_data_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [1:0]        ldsize_i,
  input  logic              ldunsigned_i,
  output logic [DATA_W-1:0] value_o,
  output logic              misaligned_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte/half, then extend according to the access size.
  always_comb begin
    byte_s       = 8'h00;
    half_s       = 16'h0000;
    value_o      = load_data_i;
    misaligned_o = 1'b0;

    case (addr_lo_i)
      2'b00:   byte_s = load_data_i[31:24];
      2'b01:   byte_s = load_data_i[23:16];
      2'b10:   byte_s = load_data_i[15:8];
      2'b11:   byte_s = load_data_i[7:0];
      default: byte_s = 8'h00;
    endcase

    if (addr_lo_i[1]) begin
      half_s = load_data_i[15:0];
    end else begin
      half_s = load_data_i[31:16];
    end

    case (ldsize_i)
      LDSIZE_HALF: begin
        misaligned_o = addr_lo_i[0];
        if (ldunsigned_i) begin
          value_o = {{(DATA_W-16){1'b0}}, half_s};
        end else begin
          value_o = {{(DATA_W-16){half_s[15]}}, half_s};
        end
      end
      LDSIZE_BYTE: begin
        misaligned_o = 1'b0;
        if (ldunsigned_i) begin
          value_o = {{(DATA_W-8){1'b0}}, byte_s};
        end else begin
          value_o = {{(DATA_W-8){byte_s[7]}}, byte_s};
        end
      end
      default: begin
        // Word and the reserved encoding both behave as a full-word load.
        misaligned_o = (addr_lo_i != 2'b00);
        value_o      = load_data_i;
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: registers the retiring instruction and drives the register-file write port.
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [ADDR_W-1:0] mem_writereg,
  input  logic [1:0]        mem_wbsel,
  input  logic [1:0]        mem_ldsize,
  input  logic              mem_ldunsigned,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [DATA_W-1:0] mem_pc,
  output logic              regwrite,
  output logic [ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0] writedata,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
  output logic              misalign,
  output logic [CNT_W-1:0]  retired_count
);

  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] writereg_q, writereg_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic              misalign_q, misalign_d;

  logic              bubble_s;
  logic              capture_s;
  logic              is_load_s;
  logic              misaligned_s;
  logic [DATA_W-1:0] ld_value_s;
  logic              ld_misaligned_s;
  logic [DATA_W-1:0] wb_value_s;

  load_extract #(
    .DATA_W (DATA_W)
  ) u_load_extract (
    .load_data_i  (mem_load_data),
    .addr_lo_i    (mem_addr_lo),
    .ldsize_i     (mem_ldsize),
    .ldunsigned_i (mem_ldunsigned),
    .value_o      (ld_value_s),
    .misaligned_o (ld_misaligned_s)
  );

  assign bubble_s     = stall | flush | ~mem_valid;
  assign capture_s    = ~bubble_s;
  assign is_load_s    = (mem_wbsel == WBSEL_LOAD);
  assign misaligned_s = is_load_s & ld_misaligned_s;

  // Writeback value mux; reserved select falls through to the ALU result.
  always_comb begin
    wb_value_s = mem_alu_result;
    case (mem_wbsel)
      WBSEL_LOAD: wb_value_s = ld_value_s;
      WBSEL_LINK: wb_value_s = mem_pc + DATA_W'(LINK_OFFSET);
      default:    wb_value_s = mem_alu_result;
    endcase
  end

  // Next state: index/data only move on a real write so the register file sees no toggling.
  always_comb begin
    regwrite_d  = 1'b0;
    misalign_d  = 1'b0;
    writereg_d  = writereg_q;
    writedata_d = writedata_q;
    if (capture_s) begin
      regwrite_d = mem_regwrite & (mem_writereg != {ADDR_W{1'b0}}) & ~misaligned_s;
      misalign_d = misaligned_s;
      if (regwrite_d) begin
        writereg_d  = mem_writereg;
        writedata_d = wb_value_s;
      end else begin
        writereg_d  = writereg_q;
        writedata_d = writedata_q;
      end
    end else begin
      regwrite_d = 1'b0;
      misalign_d = 1'b0;
    end
  end

  // Pipeline register bank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regwrite_q  <= 1'b0;
      writereg_q  <= {ADDR_W{1'b0}};
      writedata_q <= {DATA_W{1'b0}};
      misalign_q  <= 1'b0;
    end else begin
      regwrite_q  <= regwrite_d;
      writereg_q  <= writereg_d;
      writedata_q <= writedata_d;
      misalign_q  <= misalign_d;
    end
  end

  assign regwrite  = regwrite_q;
  assign writereg  = writereg_q;
  assign writedata = writedata_q;
  assign misalign  = misalign_q;
  assign fwd_valid = regwrite_q;
  assign fwd_reg   = writereg_q;
  assign fwd_data  = writedata_q;

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Misaligned loads still retire, so every capture counts.
  always_comb begin
    if (capture_s) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign retired_count = count_q;
`else
  assign retired_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic        mem_regwrite;
  logic [4:0]  mem_writereg;
  logic [1:0]  mem_wbsel;
  logic [1:0]  mem_ldsize;
  logic        mem_ldunsigned;
  logic [1:0]  mem_addr_lo;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_load_data;
  logic [31:0] mem_pc;
  logic        regwrite;
  logic [4:0]  writereg;
  logic [31:0] writedata;
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
  logic        misalign;
  logic [31:0] retired_count;

  int total;
  int fails;

  writeback_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_regwrite   (mem_regwrite),
    .mem_writereg   (mem_writereg),
    .mem_wbsel      (mem_wbsel),
    .mem_ldsize     (mem_ldsize),
    .mem_ldunsigned (mem_ldunsigned),
    .mem_addr_lo    (mem_addr_lo),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_pc         (mem_pc),
    .regwrite       (regwrite),
    .writereg       (writereg),
    .writedata      (writedata),
    .fwd_valid      (fwd_valid),
    .fwd_reg        (fwd_reg),
    .fwd_data       (fwd_data),
    .misalign       (misalign),
    .retired_count  (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string tag, input logic rw, input logic [4:0] rg,
                          input logic [31:0] d, input logic mis);
    chk({tag, ".regwrite"}, {63'd0, regwrite}, {63'd0, rw});
    chk({tag, ".writereg"}, {59'd0, writereg}, {59'd0, rg});
    chk({tag, ".writedata"}, {32'd0, writedata}, {32'd0, d});
    chk({tag, ".misalign"}, {63'd0, misalign}, {63'd0, mis});
  endtask

  task automatic set_alu(input logic [4:0] rg, input logic [31:0] alu);
    mem_valid      = 1'b1;
    mem_regwrite   = 1'b1;
    mem_writereg   = rg;
    mem_wbsel      = 2'b00;
    mem_ldsize     = 2'b00;
    mem_ldunsigned = 1'b0;
    mem_addr_lo    = 2'b00;
    mem_alu_result = alu;
  endtask

  task automatic set_load(input logic [4:0] rg, input logic [1:0] sz, input logic uns,
                          input logic [1:0] lo, input logic [31:0] data);
    mem_valid      = 1'b1;
    mem_regwrite   = 1'b1;
    mem_writereg   = rg;
    mem_wbsel      = 2'b01;
    mem_ldsize     = sz;
    mem_ldunsigned = uns;
    mem_addr_lo    = lo;
    mem_load_data  = data;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    total          = 0;
    fails          = 0;
    reset          = 1'b1;
    stall          = 1'b0;
    flush          = 1'b0;
    mem_valid      = 1'b0;
    mem_regwrite   = 1'b0;
    mem_writereg   = 5'd0;
    mem_wbsel      = 2'b00;
    mem_ldsize     = 2'b00;
    mem_ldunsigned = 1'b0;
    mem_addr_lo    = 2'b00;
    mem_alu_result = 32'h0;
    mem_load_data  = 32'h0;
    mem_pc         = 32'h0;

    #1;
    chk_port("reset", 1'b0, 5'd0, 32'h0, 1'b0);
    chk("reset.fwd_valid", {63'd0, fwd_valid}, 64'd0);
    chk("reset.count", {32'd0, retired_count}, 64'd0);
    tick();
    reset = 1'b0;

    // ALU writer
    set_alu(5'd5, 32'h0000_002A);
    tick();
    chk_port("alu", 1'b1, 5'd5, 32'h0000_002A, 1'b0);
    chk("alu.fwd_valid", {63'd0, fwd_valid}, 64'd1);
    chk("alu.fwd_reg", {59'd0, fwd_reg}, 64'd5);
    chk("alu.fwd_data", {32'd0, fwd_data}, 64'h2A);

    // lb signed, lbu offset 1
    set_load(5'd6, 2'b10, 1'b0, 2'b00, 32'h80FF_1234);
    tick();
    chk_port("lb", 1'b1, 5'd6, 32'hFFFF_FF80, 1'b0);
    set_load(5'd7, 2'b10, 1'b1, 2'b01, 32'h80FF_1234);
    tick();
    chk_port("lbu", 1'b1, 5'd7, 32'h0000_00FF, 1'b0);
    set_load(5'd7, 2'b10, 1'b0, 2'b11, 32'h80FF_1234);
    tick();
    chk_port("lb3", 1'b1, 5'd7, 32'h0000_0034, 1'b0);

    // lh signed offset 2, then misaligned lh
    set_load(5'd8, 2'b01, 1'b0, 2'b10, 32'h0000_8001);
    tick();
    chk_port("lh", 1'b1, 5'd8, 32'hFFFF_8001, 1'b0);
    set_load(5'd9, 2'b01, 1'b0, 2'b01, 32'h0000_8001);
    tick();
    chk_port("lh_mis", 1'b0, 5'd8, 32'hFFFF_8001, 1'b1);
    set_load(5'd10, 2'b01, 1'b1, 2'b00, 32'h8001_0000);
    tick();
    chk_port("lhu", 1'b1, 5'd10, 32'h0000_8001, 1'b0);
    set_load(5'd11, 2'b00, 1'b0, 2'b10, 32'hDEAD_BEEF);
    tick();
    chk_port("lw_mis", 1'b0, 5'd10, 32'h0000_8001, 1'b1);
    set_load(5'd11, 2'b00, 1'b0, 2'b00, 32'hDEAD_BEEF);
    tick();
    chk_port("lw", 1'b1, 5'd11, 32'hDEAD_BEEF, 1'b0);

    // write to $zero is never issued
    set_alu(5'd0, 32'h0000_1234);
    tick();
    chk_port("zero", 1'b0, 5'd11, 32'hDEAD_BEEF, 1'b0);

    // ALU op with stray addr_lo is not a misaligned load
    set_alu(5'd12, 32'h1357_9BDF);
    mem_addr_lo = 2'b11;
    tick();
    chk_port("alu_lo", 1'b1, 5'd12, 32'h1357_9BDF, 1'b0);

    // jal link value, then stall and flush bubbles
    set_alu(5'd31, 32'h0BAD_0BAD);
    mem_wbsel = 2'b10;
    mem_pc    = 32'h0040_0010;
    tick();
    chk_port("jal", 1'b1, 5'd31, 32'h0040_0018, 1'b0);
    set_alu(5'd3, 32'h0000_0055);
    stall = 1'b1;
    tick();
    chk_port("stall", 1'b0, 5'd31, 32'h0040_0018, 1'b0);
    chk("stall.fwd_valid", {63'd0, fwd_valid}, 64'd0);
    stall = 1'b0;
    flush = 1'b1;
    tick();
    chk_port("flush", 1'b0, 5'd31, 32'h0040_0018, 1'b0);
    flush = 1'b0;
    mem_valid = 1'b0;
    tick();
    chk_port("invalid", 1'b0, 5'd31, 32'h0040_0018, 1'b0);

    // link wraps modulo 2^32; reserved wbsel acts as ALU; non-writer stays silent
    set_alu(5'd4, 32'h0000_0077);
    mem_wbsel = 2'b10;
    mem_pc    = 32'hFFFF_FFFC;
    tick();
    chk_port("link_wrap", 1'b1, 5'd4, 32'h0000_0004, 1'b0);
    set_alu(5'd13, 32'h0000_0099);
    mem_wbsel = 2'b11;
    tick();
    chk_port("wbsel_rsvd", 1'b1, 5'd13, 32'h0000_0099, 1'b0);
    set_alu(5'd14, 32'h0000_00AA);
    mem_regwrite = 1'b0;
    tick();
    chk_port("no_write", 1'b0, 5'd13, 32'h0000_0099, 1'b0);

    // asynchronous reset mid-stream
    set_alu(5'd15, 32'h0000_0F0F);
    tick();
    chk_port("pre_reset", 1'b1, 5'd15, 32'h0000_0F0F, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_port("async_reset", 1'b0, 5'd0, 32'h0, 1'b0);
    chk("async_reset.fwd_data", {32'd0, fwd_data}, 64'd0);
    chk("async_reset.count", {32'd0, retired_count}, 64'd0);
    tick();
    chk_port("held_reset", 1'b0, 5'd0, 32'h0, 1'b0);
    reset = 1'b0;

    // 10 retiring instructions interleaved with 2 flushes
    for (int i = 0; i < 12; i++) begin
      set_alu(5'(i + 1), 32'(i));
      flush = (i == 3 || i == 7);
      tick();
      if (i == 3) begin
        chk_port("cnt_flush", 1'b0, 5'd3, 32'd2, 1'b0);
      end
    end
    flush     = 1'b0;
    mem_valid = 1'b0;
    tick();
`ifdef RETIRE_CNT_EN
    exp_cnt = 32'd10;
`else
    exp_cnt = 32'd0;
`endif
    chk("retired_count", {32'd0, retired_count}, {32'd0, exp_cnt});
    chk_port("after_cnt", 1'b0, 5'd12, 32'd11, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
